// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with split req/resp data port, load extraction, response buffering and flush discard.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   ws_allowin / ms_allowin     handshake with WB / toward EX
//   es_*                        entry offered by EX (valid, mem req, load type, we, dest, alu result, pc)
//   ms_flush, es_drop_req       kill MS entry; EX request also killed
//   data_sram_data_ok/rdata     in-order data-memory response
//   ms_to_ws_valid, ms_gr_we, ms_dest, ms_final_result, ms_pc   entry toward WB
//   ms_fwd_valid/ready/dest/data                               forwarding bus toward ID
//   ms_mem_busy                 waiting on a response or responses still to discard
module mem_stage_lsu #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ws_allowin,
    output logic          ms_allowin,
    input  logic          es_to_ms_valid,
    input  logic          es_mem_req,
    input  logic [2:0]    es_ld_op,
    input  logic          es_gr_we,
    input  logic [RW-1:0] es_dest,
    input  logic [DW-1:0] es_alu_result,
    input  logic [DW-1:0] es_pc,
    input  logic          ms_flush,
    input  logic          es_drop_req,
    input  logic          data_sram_data_ok,
    input  logic [DW-1:0] data_sram_rdata,
    output logic          ms_to_ws_valid,
    output logic          ms_gr_we,
    output logic [RW-1:0] ms_dest,
    output logic [DW-1:0] ms_final_result,
    output logic [DW-1:0] ms_pc,
    output logic          ms_fwd_valid,
    output logic          ms_fwd_ready,
    output logic [RW-1:0] ms_fwd_dest,
    output logic [DW-1:0] ms_fwd_data,
    output logic          ms_mem_busy
);
    localparam int LW = $clog2(DW / 8);

    logic            ms_valid;
    logic            req;
    logic            got_data;
    logic            gr_we;
    logic [2:0]      ld_op;
    logic [RW-1:0]   dest;
    logic [DW-1:0]   alu_result;
    logic [DW-1:0]   pc;
    logic [DW-1:0]   rdata_buf;
    logic [CNTW-1:0] discard_cnt;

    logic            discard;
    logic            resp_now;
    logic            ms_ready_go;
    logic            advance;
    logic            capture;
    logic            pending;
    logic [LW-1:0]   lane;
    logic [LW-1:0]   hlane;
    logic [LW-1:0]   wlane;
    logic [DW-1:0]   raw;
    logic [DW-1:0]   extracted;
    logic [7:0]      lb;
    logic [15:0]     lh;
    logic [31:0]     lw;

    // A nonzero discard count means the response belongs to a flushed instruction.
    assign discard     = data_sram_data_ok && discard_cnt != '0;
    assign resp_now    = data_sram_data_ok && discard_cnt == '0;
    assign ms_ready_go = !req || got_data || resp_now;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
    assign advance     = ms_to_ws_valid && ws_allowin;
    assign capture     = es_to_ms_valid && ms_allowin && !ms_flush;
    // Entry still owes a response; if flushed now, that response must be dropped.
    assign pending     = ms_valid && req && !got_data && !resp_now;

    assign raw   = got_data ? rdata_buf : data_sram_rdata;
    assign lane  = alu_result[LW-1:0];
    assign hlane = lane & ~LW'(1);
    assign wlane = lane & ~LW'(3);
    assign lb    = raw[{lane, 3'b000} +: 8];
    assign lh    = raw[{hlane, 3'b000} +: 16];
    assign lw    = raw[{wlane, 3'b000} +: 32];

    assign extracted = (ld_op == 3'd1) ? DW'($signed(lb)) :
                       (ld_op == 3'd2) ? DW'(lb) :
                       (ld_op == 3'd3) ? DW'($signed(lh)) :
                       (ld_op == 3'd4) ? DW'(lh) :
                       (ld_op == 3'd5) ? DW'($signed(lw)) :
                       (ld_op == 3'd6) ? DW'(lw) : raw;

    assign ms_gr_we        = gr_we;
    assign ms_dest         = dest;
    assign ms_pc           = pc;
    assign ms_final_result = (ld_op != 3'd0) ? extracted : alu_result;
    assign ms_fwd_valid    = ms_valid && gr_we;
    assign ms_fwd_ready    = ld_op == 3'd0 || got_data || resp_now;
    assign ms_fwd_dest     = dest;
    assign ms_fwd_data     = ms_final_result;
    assign ms_mem_busy     = (ms_valid && req && !got_data) || discard_cnt != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            req         <= 1'b0;
            ld_op       <= 3'd0;
            gr_we       <= 1'b0;
            dest        <= '0;
            alu_result  <= '0;
            pc          <= '0;
            got_data    <= 1'b0;
            rdata_buf   <= '0;
            discard_cnt <= '0;
        end else begin
            ms_valid <= ms_flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
            if (capture) begin
                req        <= es_mem_req;
                ld_op      <= es_ld_op;
                gr_we      <= es_gr_we;
                dest       <= es_dest;
                alu_result <= es_alu_result;
                pc         <= es_pc;
            end
            got_data <= (capture || ms_flush) ? 1'b0 : (resp_now && !advance) ? 1'b1 : got_data;
            if (resp_now && !advance)
                rdata_buf <= data_sram_rdata;
            discard_cnt <= discard_cnt - CNTW'(discard)
                         + (ms_flush ? CNTW'(pending) + CNTW'(es_drop_req) : '0);
        end
    end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory-access pipeline stage between EX and WB. Unlike the fixed single-cycle stage it replaces, it waits on a split request/response data-memory port (`data_ok`) rather than assuming the read data arrives one cycle after issue. It extracts byte, half and word loads with sign or zero extension. It buffers a response that arrives while WB is stalled, and it discards responses that belong to flushed instructions. It also drives a forwarding bus that tells ID whether the MS result is usable yet.

## Interface
- `DW`, 32: data/address width; legal values are 32 and 64.
- `RW`, 5: register index width.
- `CNTW`, 2: width of the discard counter. The counter must be able to hold 2.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous reset, active-high.
- `ws_allowin`  in  1  WB can accept an entry.
- `ms_allowin`  out  1  MS can accept an entry.
- `es_to_ms_valid`  in  1  EX offers an entry.
- `es_mem_req`  in  1  EX issued a data-memory request (load or store) for this entry; the request was accepted (`addr_ok`) in EX.
- `es_ld_op`  in  3  load type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD. Codes 6 and 7 are legal only when DW=64.
- `es_gr_we`  in  1  register write enable.
- `es_dest`  in  RW  destination register.
- `es_alu_result`  in  DW  ALU result or memory address.
- `es_pc`  in  DW  PC.
- `ms_flush`  in  1  kill the MS entry (exception/redirect).
- `es_drop_req`  in  1  asserted only together with `ms_flush`; EX held an issued request that is also being killed.
- `data_sram_data_ok`  in  1  one in-order response this cycle.
- `data_sram_rdata`  in  DW  response data, DW-aligned.
- `ms_to_ws_valid`  out  1  entry offered to WB.
- `ms_gr_we`  out  1  register write enable toward WB.
- `ms_dest`  out  RW  destination register toward WB.
- `ms_final_result`  out  DW  value WB writes back.
- `ms_pc`  out  DW  PC toward WB.
- `ms_fwd_valid`  out  1  `ms_valid && ms_gr_we`.
- `ms_fwd_ready`  out  1  `ms_fwd_data` is final (not a load still waiting).
- `ms_fwd_dest`  out  RW  forwarded destination.
- `ms_fwd_data`  out  DW  forwarded value; equals `ms_final_result`.
- `ms_mem_busy`  out  1  MS is waiting on a response, or `discard_cnt` != 0.

## Operation
- State registers:
  - `ms_valid`
  - entry fields: req, ld_op, gr_we, dest, alu_result, pc
  - `got_data` plus `rdata_buf[DW]`
  - `discard_cnt[CNTW]`
- Entry capture: the entry fields load when `es_to_ms_valid && ms_allowin && !ms_flush`.
- `ms_valid` update:
  - when `ms_flush`, it becomes 0 next cycle;
  - otherwise, when `ms_allowin`, it takes `es_to_ms_valid`.
- Response ownership:
  - If `data_ok` and `discard_cnt` != 0: decrement `discard_cnt`; the data is ignored.
  - Otherwise, if `data_ok`, the response belongs to the current MS entry. This requires `ms_valid && req && !got_data`; any other case is an illegal protocol condition.
- `resp_now` = `data_ok && discard_cnt==0`.
- `ms_ready_go` = `!req || got_data || resp_now`.
- `ms_allowin` = `!ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid` = `ms_valid && ms_ready_go && !ms_flush`.
- Buffering: if `resp_now` and the entry does not advance this cycle, set `got_data` and latch `rdata_buf`. `got_data` clears whenever a new entry is captured or a flush occurs.
- Load data source: `raw` = `got_data ? rdata_buf : data_sram_rdata`.
- Load extraction: the byte lane is `alu_result[log2(DW/8)-1:0]`.
  - LB / LBU: byte at lane, sign/zero extended to DW.
  - LH / LHU: half at `lane & ~1`, sign/zero extended.
  - LW / LWU: word at `lane & ~3`, sign/zero extended.
  - LD: the full word.
  - Misaligned addresses are handled by EX and never reach MS.
- `ms_final_result` = `(ld_op != 0) ? extracted : alu_result`. Stores have `req=1`, `ld_op=0`, and `gr_we=0`.
- `ms_fwd_ready` = `ld_op==0 || got_data || resp_now`.
- Flush handling:
  - `discard_cnt` next = current − (discard this cycle) + (`ms_valid && req && !got_data && !resp_now`) + `es_drop_req`.
  - A flush in the same cycle as that entry's own `resp_now` consumes the response and adds no count.

## Timing
- Reset (async) values: `ms_valid`, `got_data`, `discard_cnt`, and all entry fields are 0. Hence `ms_to_ws_valid`=0, `ms_fwd_valid`=0, `ms_allowin`=1, `ms_mem_busy`=0.
- Non-memory entry: passes to WB the cycle after capture, when `ws_allowin`=1.
- Load whose `data_ok` arrives in the first MS cycle: zero added latency. The result is combinational from `data_sram_rdata`.
- Each cycle without `data_ok` adds one stall cycle. The result is held in `rdata_buf` until WB accepts the entry.
- Back-to-back: a new entry is captured in the same cycle the old one transfers.
- Flush plus a valid EX offer in the same cycle: the offer is not captured.

## Test plan
- ALU entry `alu_result`=0x1234, `ws_allowin`=1 -> `ms_to_ws_valid` goes high 1 cycle after capture with `ms_final_result`=0x1234, and `ms_fwd_ready`=1.
- LB at address 0x...3 with rdata 0x80FF_0000, `data_ok` 3 cycles late -> `ms_to_ws_valid`=0 and `ms_fwd_ready`=0 for 3 cycles, then result 0xFFFF_FF80; LBU of the same access -> 0x0000_0080.
- LH at lane 2, rdata 0x8001_0000, `data_ok` while `ws_allowin`=0 for 2 cycles -> `got_data`=1, `ms_mem_busy`=0, and on release the result is 0xFFFF_8001.
- Pending LW with `ms_flush` and `es_drop_req`=1 -> `discard_cnt`=2. The next two `data_ok` pulses are ignored. A new load's response, arriving as the third pulse, returns its own data.
- Flush in the same cycle as the pending load's `data_ok` -> `discard_cnt` stays 0, and `ms_to_ws_valid` stays 0.
- DW=64, LWU at lane 4, rdata 0xFFFF_FFFF_0000_0000 -> result 0x0000_0000_FFFF_FFFF. Assert `reset` mid-stall -> all outputs return to their reset values immediately.
